sram_responder: RTL and testbench
=================================

// Module: sram_responder
// PURPOSE
//  Synthesizable cycle-level model of the external 256Kx16 SRAM chip: the device end of the SRAM bus
//  driven by the MEM-stage SRAM controller. Samples ADDR/CE_N/WE_N/OE_N/UB_N/LB_N on clk.
//  Performs byte-masked writes and returns read data on a tristated DQ after a programmable latency.
//  Used on the board-level bench under the ARM top and as the SRAM stand-in for FPGA loopback builds.
// PARAMETERS
//  ADDR_W    18     address width (word addressed, 16-bit words)
//  DATA_W    16     DQ width; split into UB [15:8] and LB [7:0]
//  DEPTH     65536  implemented words; physical index = SRAM_ADDR mod DEPTH (DEPTH power of 2)
//  READ_LAT  2      cycles from read issue to DQ driven, 1..7
// PORTS
//  clk        in     1       system clock, all sampling on rising edge
//  rst        in     1       asynchronous, active-low reset
//  SRAM_ADDR  in     ADDR_W  word address
//  SRAM_DQ    inout  DATA_W  data bus; driven only in RD_DRIVE, else 'z
//  SRAM_CE_N  in     1       chip enable, active low
//  SRAM_WE_N  in     1       write enable, active low, dominates OE_N
//  SRAM_OE_N  in     1       output enable, active low
//  SRAM_UB_N  in     1       upper byte enable, active low
//  SRAM_LB_N  in     1       lower byte enable, active low
//  rd_count   out    16      completed reads (wraps at 2^16)
//  wr_count   out    16      accepted writes (wraps at 2^16)
//  proto_err  out    1       sticky: WE_N=0 and OE_N=0 sampled together with CE_N=0
// BEHAVIOUR
//  Reset (rst=0, any time): FSM->IDLE, DQ='z, lat_cnt=0, rd_count=0, wr_count=0, proto_err=0.
//   Array contents are NOT cleared. A read in flight is aborted with no DQ glitch.
//  Select: cycle is active iff CE_N=0. CE_N=1 -> IDLE next cycle, DQ='z, no side effects.
//  Write: CE_N=0 & WE_N=0 at an edge -> mem[a][15:8]<=DQ[15:8] if UB_N=0; mem[a][7:0]<=DQ[7:0] if LB_N=0.
//   wr_count+1 only if at least one byte is enabled. WE_N=0 forces IDLE (aborts any read).
//  Read issue: CE_N=0 & WE_N=1 & OE_N=0 in IDLE -> latch addr, lat_cnt<=READ_LAT-1, go RD_WAIT
//   (READ_LAT=1: straight to RD_DRIVE).
//  RD_WAIT: lat_cnt-- each cycle; when 0 -> RD_DRIVE. SRAM_ADDR change -> relatch, reload lat_cnt.
//   OE_N=1 -> IDLE.
//  RD_DRIVE: DQ = mem[latched addr] sampled at entry; disabled byte lanes (UB_N/LB_N=1) are 'z.
//   rd_count+1 on entry. Holds while CE_N=0, WE_N=1, OE_N=0, addr stable.
//   Addr change -> RD_WAIT with reload (back-to-back reads: each new addr costs READ_LAT cycles).
//   OE_N=1 or CE_N=1 -> IDLE, DQ released same edge.
//  Write-then-read: write at edge t, read issued at t+1 returns the new data (no stale bypass needed;
//   array updated at t).
//  proto_err: set on any edge with CE_N=0, WE_N=0, OE_N=0; write still performed; clears only on reset.
//  Counters wrap modulo 2^16 silently.
//  States (2-bit, one-hot not required): IDLE=0, RD_WAIT=1, RD_DRIVE=2; 3 unreachable -> IDLE.
// STRUCTURE
//  Shared include sram_defs.vh: SRAM_ADDR_W, SRAM_DATA_W, state encodings, READ_LAT bounds.
//  One sub-module: sram_byte_array (DEPTH x 2 byte-lane RAM, sync write per lane, registered read)
//   so it maps to block RAM; responder holds FSM, latency counter, tristate control, counters.
// TESTING
//  1 Reset mid-read: issue read, assert rst at lat_cnt=1 -> DQ stays 'z, FSM IDLE, counters 0.
//  2 Write 0xBEEF @0x00010 both bytes, read @0x00010 -> DQ=0xBEEF exactly READ_LAT cycles after
//    issue; rd_count=1, wr_count=1.
//  3 Byte mask: mem@0x5=0x1234, write 0xABCD with UB_N=1 -> read 0x12CD; read with LB_N=1 ->
//    DQ[7:0]='z, DQ[15:8]=0x12.
//  4 Address alias: write 0x5A5A @0x10005 (DEPTH=65536) -> read @0x00005 returns 0x5A5A.
//  5 Back-to-back reads @0x1,@0x2 with OE_N held low -> two data phases, each READ_LAT after addr
//    change; rd_count=2.
//  6 Protocol error: CE_N=0,WE_N=0,OE_N=0 with DQ=0x0F0F @0x7 -> proto_err=1 (sticky), mem@0x7=0x0F0F,
//    DQ never driven by responder.

Source files
------------

// File: rtl/sram_responder_pkg.sv
// Shared SRAM bus widths, read-latency bounds and responder states.
// Imported by the responder top and its byte-lane array.
package sram_responder_pkg;

  localparam int SRAM_ADDR_W  = 18;
  localparam int SRAM_DATA_W  = 16;
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2
  } state_t;

endpackage

// File: rtl/sram_byte_array.sv
// DEPTH x two byte-lane RAM: per-lane sync write, registered read.
// Ports: clk, addr, we_hi/we_lo lane writes, wdata, re read strobe, rdata.
module sram_byte_array #(
  parameter int DEPTH  = 65536,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 16
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  addr,
  input  logic              we_hi,
  input  logic              we_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  localparam int H = DATA_W / 2;

  logic [H-1:0] mem_hi [DEPTH];
  logic [H-1:0] mem_lo [DEPTH];

  always_ff @(posedge clk) begin
    if (we_hi) mem_hi[addr] <= wdata[DATA_W-1:H];
    if (we_lo) mem_lo[addr] <= wdata[H-1:0];
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= {mem_hi[addr], mem_lo[addr]};
  end

endmodule

// File: rtl/sram_responder.sv
// Device end of the SRAM bus: byte-masked writes, latency-delayed reads.
// Ports: clk, rst (async low), SRAM_* bus, rd_count, wr_count, proto_err.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DATA_W   = SRAM_DATA_W,
  parameter int DEPTH    = 65536,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_OE_N,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              proto_err
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam int         H        = DATA_W / 2;
  localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);
  localparam logic       LAT1     = (READ_LAT == 1);

  state_t              state;
  logic [2:0]          lat_cnt;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rdata;

  logic wr;
  logic rd_req;
  logic addr_chg;
  logic load;
  logic go_drive;
  logic drive;

  assign wr       = !SRAM_CE_N && !SRAM_WE_N;
  assign rd_req   = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
  assign addr_chg = SRAM_ADDR != rd_addr;
  assign load     = rd_req && (state == IDLE ||
                    ((state == RD_WAIT || state == RD_DRIVE)
                     && addr_chg));
  // Entering RD_DRIVE always happens with SRAM_ADDR equal to the
  // read target, so the array is read straight off the bus address.
  assign go_drive = load ? LAT1
                  : (rd_req && state == RD_WAIT
                     && lat_cnt <= 3'd1);
  assign drive    = state == RD_DRIVE;

  sram_byte_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .addr  (SRAM_ADDR[IDX_W-1:0]),
    .we_hi (wr && !SRAM_UB_N),
    .we_lo (wr && !SRAM_LB_N),
    .wdata (SRAM_DQ),
    .re    (go_drive),
    .rdata (rdata)
  );

  assign SRAM_DQ[DATA_W-1:H] = (drive && !SRAM_UB_N)
                             ? rdata[DATA_W-1:H] : {H{1'bz}};
  assign SRAM_DQ[H-1:0]      = (drive && !SRAM_LB_N)
                             ? rdata[H-1:0] : {H{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      rd_addr   <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (wr && !SRAM_OE_N) proto_err <= 1'b1;
      if (wr && (!SRAM_UB_N || !SRAM_LB_N))
        wr_count <= wr_count + 16'd1;
      if (go_drive) rd_count <= rd_count + 16'd1;
      if (!rd_req) begin
        state   <= IDLE;
        lat_cnt <= '0;
      end else if (load) begin
        rd_addr <= SRAM_ADDR;
        lat_cnt <= LAT_LOAD;
        state   <= go_drive ? RD_DRIVE : RD_WAIT;
      end else begin
        unique case (state)
          RD_WAIT: begin
            if (go_drive) state <= RD_DRIVE;
            else lat_cnt <= lat_cnt - 3'd1;
          end
          RD_DRIVE: state <= RD_DRIVE;
          default:  state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: vector table plus corner sequences.
// The DQ bus is pulled up, so a released lane reads back as all ones.
module tb_sram_responder;

  localparam int LAT = 2;
  localparam logic [15:0] RELEASED = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] addr = '0;
  logic        ce_n = 1'b1;
  logic        we_n = 1'b1;
  logic        oe_n = 1'b1;
  logic        ub_n = 1'b1;
  logic        lb_n = 1'b1;
  logic [15:0] tb_dq = '0;
  logic        tb_dq_en = 1'b0;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic        proto_err;
  wire  [15:0] dq;

  int total = 0;
  int passed = 0;

  assign dq = tb_dq_en ? tb_dq : 16'hzzzz;

  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (dq[i]);
  end

  always #5 clk = ~clk;

  sram_responder #(.READ_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .SRAM_ADDR (addr),
    .SRAM_DQ   (dq),
    .SRAM_CE_N (ce_n),
    .SRAM_WE_N (we_n),
    .SRAM_OE_N (oe_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .proto_err (proto_err)
  );

  typedef struct {
    logic        do_wr;
    logic [17:0] waddr;
    logic [15:0] wdata;
    logic        wub;
    logic        wlb;
    logic [17:0] raddr;
    logic        rub;
    logic        rlb;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus(input logic ce, we, oe, ub, lb,
                     input logic [17:0] a);
    ce_n = ce; we_n = we; oe_n = oe;
    ub_n = ub; lb_n = lb; addr = a;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                          input logic ub, lb);
    bus(1'b0, 1'b0, 1'b1, ub, lb, a);
    tb_dq = d;
    tb_dq_en = 1'b1;
    tick();
    tb_dq_en = 1'b0;
    bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, a);
  endtask

  task automatic do_read(input logic [17:0] a, input logic ub, lb,
                         input logic [15:0] exp, input string nm);
    tb_dq_en = 1'b0;
    bus(1'b0, 1'b1, 1'b0, ub, lb, a);
    tick();
    for (int k = 1; k < LAT; k++) begin
      chk({nm, "_wait"}, dq, RELEASED);
      tick();
    end
    chk(nm, dq, exp);
    bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, a);
    tick();
    chk({nm, "_rel"}, dq, RELEASED);
  endtask

  initial begin
    vecs[0] = '{1, 18'h00010, 16'hBEEF, 0, 0, 18'h00010, 0, 0, 16'hBEEF};
    vecs[1] = '{1, 18'h00005, 16'h1234, 0, 0, 18'h00005, 0, 0, 16'h1234};
    vecs[2] = '{1, 18'h00005, 16'hABCD, 1, 0, 18'h00005, 0, 0, 16'h12CD};
    vecs[3] = '{1, 18'h00005, 16'hFFFF, 1, 1, 18'h00005, 0, 1, 16'h12FF};
    vecs[4] = '{1, 18'h10005, 16'h5A5A, 0, 0, 18'h00005, 0, 0, 16'h5A5A};
    vecs[5] = '{1, 18'h3FFFF, 16'hC3A5, 0, 0, 18'h0FFFF, 0, 0, 16'hC3A5};
    vecs[6] = '{0, 18'h00000, 16'h0000, 1, 1, 18'h00010, 1, 0, 16'hFFEF};

    // reset state
    repeat (2) tick();
    chk("rst_dq", dq, RELEASED);
    chk("rst_rd_count", rd_count, 16'd0);
    chk("rst_wr_count", wr_count, 16'd0);
    chk("rst_proto", {15'd0, proto_err}, 16'd0);
    rst = 1'b1;
    tick();

    // reset while a read waits with lat_cnt=1
    bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00003);
    tick();
    #2 rst = 1'b0;
    #1 chk("midrd_dq_now", dq, RELEASED);
    tick();
    chk("midrd_dq", dq, RELEASED);
    chk("midrd_rd_count", rd_count, 16'd0);
    bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0);
    rst = 1'b1;
    tick();
    chk("midrd_after", dq, RELEASED);

    // table: write then read the next cycle
    for (int i = 0; i < 7; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      if (vecs[i].do_wr)
        do_write(vecs[i].waddr, vecs[i].wdata,
                 vecs[i].wub, vecs[i].wlb);
      do_read(vecs[i].raddr, vecs[i].rub, vecs[i].rlb,
              vecs[i].exp, nm);
      if (i == 0) begin
        chk("vec0_rd_count", rd_count, 16'd1);
        chk("vec0_wr_count", wr_count, 16'd1);
      end
    end
    chk("tbl_rd_count", rd_count, 16'd7);
    chk("tbl_wr_count", wr_count, 16'd5);

    // OE_N released while waiting aborts the read
    bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00010);
    tick();
    oe_n = 1'b1;
    tick();
    chk("oe_abort_dq", dq, RELEASED);
    bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0);
    tick();
    chk("oe_abort_dq2", dq, RELEASED);
    chk("oe_abort_rd_count", rd_count, 16'd7);

    // back-to-back reads with OE_N held low
    do_write(18'h00001, 16'h1111, 1'b0, 1'b0);
    do_write(18'h00002, 16'h2222, 1'b0, 1'b0);
    bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00001);
    tick();
    chk("b2b_w1", dq, RELEASED);
    tick();
    chk("b2b_d1", dq, 16'h1111);
    addr = 18'h00002;
    tick();
    chk("b2b_w2", dq, RELEASED);
    tick();
    chk("b2b_d2", dq, 16'h2222);
    tick();
    chk("b2b_hold", dq, 16'h2222);
    chk("b2b_rd_count", rd_count, 16'd9);
    bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0);
    tick();
    chk("b2b_rel", dq, RELEASED);

    // WE_N and OE_N low together
    chk("proto_pre", {15'd0, proto_err}, 16'd0);
    bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00007);
    tb_dq = 16'h0F0F;
    tb_dq_en = 1'b1;
    tick();
    chk("proto_set", {15'd0, proto_err}, 16'd1);
    tb_dq_en = 1'b0;
    #1 chk("proto_dq_undriven", dq, RELEASED);
    bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0);
    repeat (3) tick();
    chk("proto_sticky", {15'd0, proto_err}, 16'd1);
    chk("proto_wr_count", wr_count, 16'd8);
    do_read(18'h00007, 1'b0, 1'b0, 16'h0F0F, "proto_mem");
    chk("proto_rd_count", rd_count, 16'd10);

    // reset clears status but keeps array contents
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rst2_proto", {15'd0, proto_err}, 16'd0);
    chk("rst2_wr_count", wr_count, 16'd0);
    do_read(18'h00007, 1'b0, 1'b0, 16'h0F0F, "rst2_mem");
    chk("rst2_rd_count", rd_count, 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
